// File: rtl/resp_chk_pkg.sv
// resp_checker shared types and helpers.
// FSM state encoding and a width-aware saturating add.
package resp_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Add a+b and clamp to the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b,
    input int unsigned w
  );
    logic [32:0] s;
    logic [32:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = (33'd1 << w) - 33'd1;
    return (s > m) ? m[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/resp_chk_if.sv
// resp_checker expected/actual handshake bundle.
// master drives valid/data, slave returns ready.
interface resp_chk_if #(
  parameter int WIDTH = 8
);
  logic             exp_valid;
  logic [WIDTH-1:0] exp_data;
  logic             exp_ready;
  logic             act_valid;
  logic [WIDTH-1:0] act_data;
  logic             act_ready;

  modport master (
    output exp_valid, exp_data,
    output act_valid, act_data,
    input  exp_ready, act_ready
  );

  modport slave (
    input  exp_valid, exp_data,
    input  act_valid, act_data,
    output exp_ready, act_ready
  );
endinterface

// File: rtl/resp_chk_fifo.sv
// Expected-value queue, show-ahead head.
// Extra pointer MSB separates full from empty.
module resp_chk_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  import resp_chk_pkg::*;

  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr;
  logic [AW:0]      rd;

  assign empty = (wr == rd);
  assign full  = (wr[AW] != rd[AW]) &&
                 (wr[AW-1:0] == rd[AW-1:0]);
  assign count = wr - rd;
  assign dout  = mem[rd[AW-1:0]];

  // Pointer update; clear drops every entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr <= '0;
      rd <= '0;
    end else if (clear) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push && !full)  wr <= wr + ONE;
      if (pop  && !empty) rd <= rd + ONE;
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (push && !full && !clear)
      mem[wr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/resp_checker.sv
// In-order response checker with expected queue.
// Counts compares/errors, keeps first mismatch.
module resp_checker #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 finish,
  resp_chk_if.slave            bus,
  output logic                 mismatch,
  output logic [CNT_WIDTH-1:0] cmp_count,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [WIDTH-1:0]     first_err_exp,
  output logic [WIDTH-1:0]     first_err_act,
  output logic                 done,
  output logic                 pass
);
  import resp_chk_pkg::*;

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] RUN   = ST_RUN;
  localparam logic [1:0] FLUSH = ST_FLUSH;
  localparam logic [1:0] DONE  = ST_DONE;

  logic [1:0]       state;
  logic             full;
  logic             empty;
  logic [AW:0]      occ;
  logic [WIDTH-1:0] head;
  logic             push;
  logic             pop;
  logic             neq;
  logic             start_run;
  logic             have_first;

  assign start_run     = start && (state != FLUSH);
  assign bus.exp_ready = (state == RUN) && !full;
  assign bus.act_ready = (state == RUN) && !empty;
  assign push          = bus.exp_valid && bus.exp_ready;
  assign pop           = bus.act_valid && bus.act_ready;
  assign neq           = (bus.act_data != head);
  assign done          = (state == DONE);
  assign pass          = done && (err_count == '0);

  resp_chk_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (start_run || (state == FLUSH)),
    .push  (push),
    .din   (bus.exp_data),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (occ)
  );

  // Run control; start overrides finish.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else if (start_run) begin
      state <= RUN;
    end else begin
      unique case (state)
        IDLE:    state <= IDLE;
        RUN:     if (finish) state <= FLUSH;
        FLUSH:   state <= DONE;
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // Registered compare of each popped pair, plus flush accounting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mismatch      <= 1'b0;
      cmp_count     <= '0;
      err_count     <= '0;
      first_err_exp <= '0;
      first_err_act <= '0;
      have_first    <= 1'b0;
    end else if (start_run) begin
      mismatch      <= 1'b0;
      cmp_count     <= '0;
      err_count     <= '0;
      first_err_exp <= '0;
      first_err_act <= '0;
      have_first    <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      if (pop) begin
        cmp_count <= CNT_WIDTH'(sat_add(
          32'(cmp_count), 32'd1, CNT_WIDTH));
        if (neq) begin
          mismatch  <= 1'b1;
          err_count <= CNT_WIDTH'(sat_add(
            32'(err_count), 32'd1, CNT_WIDTH));
          if (!have_first) begin
            have_first    <= 1'b1;
            first_err_exp <= head;
            first_err_act <= bus.act_data;
          end
        end
      end
      if (state == FLUSH)
        err_count <= CNT_WIDTH'(sat_add(
          32'(err_count), 32'(occ), CNT_WIDTH));
    end
  end

endmodule

// File: tb/tb_resp_checker.sv
// Scoreboard bench for resp_checker.
// Expecteds queued on push, checked on DUT result.
module tb_resp_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic finish = 1'b0;

  always #5 clk = ~clk;

  resp_chk_if #(.WIDTH(8)) bus();

  logic        mismatch;
  logic [15:0] cmp_count;
  logic [15:0] err_count;
  logic [7:0]  first_err_exp;
  logic [7:0]  first_err_act;
  logic        done;
  logic        pass;

  resp_checker #(
    .WIDTH(8), .DEPTH(8), .CNT_WIDTH(16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .finish        (finish),
    .bus           (bus),
    .mismatch      (mismatch),
    .cmp_count     (cmp_count),
    .err_count     (err_count),
    .first_err_exp (first_err_exp),
    .first_err_act (first_err_act),
    .done          (done),
    .pass          (pass)
  );

  int total = 0;
  int bad = 0;

  logic [7:0] sb[$];
  int         m_cmp;
  int         m_err;
  logic       m_mis;
  logic       m_first;
  logic [7:0] m_fe;
  logic [7:0] m_fa;
  logic       last_push;
  logic       last_pop;

  task automatic model_clear();
    sb.delete();
    m_cmp = 0; m_err = 0; m_mis = 0;
    m_first = 0; m_fe = 0; m_fa = 0;
  endtask

  task automatic model_flush();
    m_err = m_err + sb.size();
    sb.delete();
  endtask

  task automatic cycle();
    logic hp, ha, st;
    logic [7:0] dp, da, e;
    #1;
    hp = bus.exp_valid && bus.exp_ready;
    ha = bus.act_valid && bus.act_ready;
    dp = bus.exp_data;
    da = bus.act_data;
    st = start;
    @(posedge clk);
    #1;
    last_push = hp;
    last_pop = ha;
    m_mis = 0;
    if (st) begin
      model_clear();
    end else begin
      if (ha) begin
        e = sb.pop_front();
        m_cmp++;
        if (e !== da) begin
          m_err++;
          m_mis = 1;
          if (!m_first) begin
            m_first = 1; m_fe = e; m_fa = da;
          end
        end
      end
      if (hp) sb.push_back(dp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic push(input logic [7:0] v);
    int n = 0;
    bus.exp_valid = 1'b1;
    bus.exp_data = v;
    do begin cycle(); n++; end
    while (!last_push && n < 20);
    bus.exp_valid = 1'b0;
    total++;
    if (last_push !== 1'b1) begin
      bad++;
      $display("FAIL push_timeout: got %b want 1", last_push);
    end
  endtask

  task automatic act(input logic [7:0] v);
    int n = 0;
    bus.act_valid = 1'b1;
    bus.act_data = v;
    do begin cycle(); n++; end
    while (!last_pop && n < 20);
    bus.act_valid = 1'b0;
    total++;
    if (last_pop !== 1'b1) begin
      bad++;
      $display("FAIL act_timeout: got %b want 1", last_pop);
    end
  endtask

  task automatic test_reset();
    bus.exp_valid = 0; bus.exp_data = 0;
    bus.act_valid = 0; bus.act_data = 0;
    model_clear();
    #2 rst = 1'b0;
    #2;
    total++;
    if ({mismatch, cmp_count, err_count, done, pass} !== '0) begin
      bad++;
      $display("FAIL reset_init: got %h want 0",
        {mismatch, cmp_count, err_count, done, pass});
    end
    @(posedge clk); #1 rst = 1'b1;
    pulse_start();
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
    #3 rst = 1'b0;
    #1;
    total++;
    if ({bus.exp_ready, bus.act_ready} !== 2'b00) begin
      bad++;
      $display("FAIL reset_ready: got %b want 00",
        {bus.exp_ready, bus.act_ready});
    end
    total++;
    if ({first_err_exp, first_err_act, cmp_count,
         err_count, mismatch, done, pass} !== '0) begin
      bad++;
      $display("FAIL reset_outs: got nonzero");
    end
    model_clear();
    @(posedge clk); #1 rst = 1'b1;
    bus.exp_valid = 1; bus.act_valid = 1;
    repeat (3) cycle();
    total++;
    if ({bus.exp_ready, bus.act_ready, last_push} !== 3'b000) begin
      bad++;
      $display("FAIL reset_idle: got %b want 000",
        {bus.exp_ready, bus.act_ready, last_push});
    end
    bus.exp_valid = 0; bus.act_valid = 0;
  endtask

  task automatic test_clean();
    pulse_start();
    push(8'h11); push(8'h22); push(8'h33);
    act(8'h11); act(8'h22); act(8'h33);
    total++;
    if (mismatch !== m_mis) begin
      bad++;
      $display("FAIL clean_mis: got %b want %b", mismatch, m_mis);
    end
    finish = 1'b1; cycle(); finish = 1'b0;
    model_flush();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL clean_flush_done: got %b want 0", done);
    end
    cycle();
    total++;
    if ({done, pass} !== 2'b11) begin
      bad++;
      $display("FAIL clean_pass: got %b want 11", {done, pass});
    end
    total++;
    if (cmp_count !== 16'(m_cmp) || m_cmp != 3) begin
      bad++;
      $display("FAIL clean_cmp: got %0d want 3", cmp_count);
    end
    total++;
    if (err_count !== 16'(m_err)) begin
      bad++;
      $display("FAIL clean_err: got %0d want %0d", err_count, m_err);
    end
  endtask

  task automatic test_mismatch();
    pulse_start();
    push(8'hA5);
    act(8'h5A);
    total++;
    if ({mismatch, err_count} !== {m_mis, 16'(m_err)}
        || m_err != 1) begin
      bad++;
      $display("FAIL mis_first: got %b/%0d want 1/1",
        mismatch, err_count);
    end
    total++;
    if ({first_err_exp, first_err_act} !== {m_fe, m_fa}
        || m_fe != 8'hA5) begin
      bad++;
      $display("FAIL mis_capture: got %h/%h want a5/5a",
        first_err_exp, first_err_act);
    end
    cycle();
    total++;
    if (mismatch !== 1'b0) begin
      bad++;
      $display("FAIL mis_pulse_width: got %b want 0", mismatch);
    end
    push(8'h01);
    act(8'h02);
    total++;
    if ({mismatch, err_count} !== {1'b1, 16'(m_err)}) begin
      bad++;
      $display("FAIL mis_second: got %b/%0d want 1/%0d",
        mismatch, err_count, m_err);
    end
    total++;
    if ({first_err_exp, first_err_act} !== {8'hA5, 8'h5A}) begin
      bad++;
      $display("FAIL mis_keep_first: got %h/%h want a5/5a",
        first_err_exp, first_err_act);
    end
  endtask

  task automatic test_full();
    pulse_start();
    for (int i = 0; i < 8; i++) push(8'h80 + 8'(i));
    total++;
    if (bus.exp_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_ready: got %b want 0", bus.exp_ready);
    end
    bus.exp_valid = 1; bus.exp_data = 8'h99;
    cycle();
    total++;
    if ({last_push, bus.exp_ready} !== 2'b00) begin
      bad++;
      $display("FAIL full_hold: got %b want 00",
        {last_push, bus.exp_ready});
    end
    bus.act_valid = 1; bus.act_data = sb[0];
    cycle();
    bus.act_valid = 0;
    total++;
    if ({last_pop, last_push, bus.exp_ready} !== 3'b101) begin
      bad++;
      $display("FAIL full_free: got %b want 101",
        {last_pop, last_push, bus.exp_ready});
    end
    cycle();
    bus.exp_valid = 0;
    total++;
    if ({last_push, bus.exp_ready} !== 2'b10) begin
      bad++;
      $display("FAIL full_accept9: got %b want 10",
        {last_push, bus.exp_ready});
    end
  endtask

  task automatic test_leftover();
    pulse_start();
    for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
    act(8'h40);
    finish = 1; bus.act_valid = 1; bus.act_data = 8'h41;
    cycle();
    finish = 0; bus.act_valid = 0;
    total++;
    if (last_pop !== 1'b1) begin
      bad++;
      $display("FAIL left_hs: got %b want 1", last_pop);
    end
    model_flush();
    cycle();
    total++;
    if ({done, pass} !== 2'b10) begin
      bad++;
      $display("FAIL left_done: got %b want 10", {done, pass});
    end
    total++;
    if (err_count !== 16'(m_err) || m_err != 2) begin
      bad++;
      $display("FAIL left_err: got %0d want 2", err_count);
    end
    total++;
    if (cmp_count !== 16'(m_cmp) || m_cmp != 2) begin
      bad++;
      $display("FAIL left_cmp: got %0d want 2", cmp_count);
    end
  endtask

  task automatic test_collision();
    pulse_start();
    push(8'h01); push(8'h02); push(8'h03);
    act(8'hF1); act(8'hF2); act(8'hF3);
    total++;
    if (err_count !== 16'd3) begin
      bad++;
      $display("FAIL coll_pre: got %0d want 3", err_count);
    end
    start = 1; finish = 1;
    cycle();
    start = 0; finish = 0;
    total++;
    if ({cmp_count, err_count, first_err_exp, done} !== '0) begin
      bad++;
      $display("FAIL coll_clear: got %0d/%0d/%h/%b want 0",
        cmp_count, err_count, first_err_exp, done);
    end
    cycle();
    total++;
    if ({done, bus.exp_ready} !== 2'b01) begin
      bad++;
      $display("FAIL coll_run: got %b want 01",
        {done, bus.exp_ready});
    end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      bus.exp_valid = 1;
      bus.exp_data = 8'($urandom);
      bus.act_valid = 1'($urandom_range(0, 1));
      if (sb.size() != 0)
        bus.act_data = ($urandom_range(0, 3) == 0) ? ~sb[0] : sb[0];
      else
        bus.act_data = 8'($urandom);
      cycle();
      total++;
      if (mismatch !== m_mis) begin
        bad++;
        $display("FAIL b2b_mis[%0d]: got %b want %b",
          i, mismatch, m_mis);
      end
    end
    bus.exp_valid = 0; bus.act_valid = 0;
    finish = 1; cycle(); finish = 0;
    model_flush();
    cycle();
    total++;
    if ({cmp_count, err_count} !== {16'(m_cmp), 16'(m_err)}) begin
      bad++;
      $display("FAIL b2b_counts: got %0d/%0d want %0d/%0d",
        cmp_count, err_count, m_cmp, m_err);
    end
    total++;
    if (pass !== (m_err == 0)) begin
      bad++;
      $display("FAIL b2b_pass: got %b want %b", pass, m_err == 0);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_mismatch();
    test_full();
    test_leftover();
    test_collision();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/resp_checker.md
# resp_checker

Response checker that sits on the output side of a generated DUT and closes the loop the test-bench generator opens: the stimulus side drives `data_in` and `x`, and this block consumes the DUT's `data_out` stream. Expected values are queued through one valid/ready port and actual DUT results arrive on a second. Each actual is compared in order against the oldest expected entry. Pass/fail, counts and the first mismatch are reported as registered status.

## Interface
- `WIDTH`, 8, data width; matches DUT `data_out`.
- `DEPTH`, 8, expected-queue depth; power of two, ≥2.
- `CNT_WIDTH`, 16, width of all counters.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse; clears all status and enters RUN.
- `finish`  in  1  pulse; ends the run.
- `exp_valid`  in  1  expected value offered.
- `exp_data`  in  WIDTH  expected value.
- `exp_ready`  out  1  queue accepts an expected value.
- `act_valid`  in  1  DUT result offered.
- `act_data`  in  WIDTH  DUT result (`data_out`).
- `act_ready`  out  1  checker accepts a result.
- `mismatch`  out  1  one-cycle pulse per failed compare.
- `cmp_count`  out  CNT_WIDTH  compares performed.
- `err_count`  out  CNT_WIDTH  mismatches plus unconsumed expecteds.
- `first_err_exp`  out  WIDTH  expected value of the first mismatch.
- `first_err_act`  out  WIDTH  actual value of the first mismatch.
- `done`  out  1  high in DONE.
- `pass`  out  1  `done && err_count==0`.

## Operation
- FSM states are IDLE, RUN, FLUSH and DONE. Reset enters IDLE.
- IDLE→RUN on `start`. DONE→RUN on `start`.
- `start` in RUN restarts the run.
- RUN→FLUSH on `finish`. FLUSH→DONE unconditionally.
- If `start` and `finish` are sampled together, `start` wins.
- Entering RUN via `start` does all of the following:
  - clears the queue, counters, `first_err_*` and the pending compare;
  - clears `done`.
- `exp_ready = (state==RUN) && !full`.
- A push happens when `exp_valid && exp_ready`.
- When full, a push is refused even if a pop occurs in the same cycle. There is no full-bypass.
- `act_ready = (state==RUN) && !empty`. There is no empty-bypass: a push into an empty queue is not visible to `act_ready` until the next cycle.
- On an act handshake:
  - the head entry is popped;
  - `act_data` and the head value are registered into a one-stage compare pipeline.
- The cycle after the handshake:
  - `cmp_count` increments;
  - on inequality, `mismatch` pulses and `err_count` increments;
  - on the first mismatch of the run, `first_err_exp` and `first_err_act` are captured.
- FLUSH lasts one cycle:
  - the compare still pending from the last RUN cycle retires;
  - `err_count` increases by the queue occupancy;
  - the queue is cleared.
- Both counters saturate at all-ones.
- `err_count` is `err_count` + occupancy + pending-mismatch, saturated.
- Comparison is full-width unsigned equality.

## Timing
- Reset values: every output is 0 and the state is IDLE. Reset clears the queue pointers; queue contents are don't-care.
- Reset asserted mid-run clears everything asynchronously. After release the block waits in IDLE.
- Compare latency: a handshake in cycle n produces its result (`mismatch`, counters) in cycle n+1.
- `finish` sampled in cycle n:
  - FLUSH in n+1;
  - `done` and `pass` valid in n+2;
  - both hold until `start` or reset.
- A queue pop frees space, visible on `exp_ready` the next cycle.
- Queue pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer MSB.

## Structure
- Package `resp_chk_pkg` holds:
  - the state enum (IDLE/RUN/FLUSH/DONE);
  - a saturating-add function parameterised on width.
- Sub-module `resp_chk_fifo`: synchronous FIFO with `push`, `pop`, `din`, `dout` (head, show-ahead), `full`, `empty`, `count`, `clear`, and the same asynchronous active-low `rst`.
- The top level contains the FSM, the compare stage and the counters.

## Test plan
- Reset: pulse `rst` low mid-run with 5 entries queued. All outputs are 0 immediately. After release, `exp_ready` and `act_ready` stay 0 until `start`.
- Clean run: `start`; push 0x11, 0x22, 0x33; feed the same actuals; `finish`. Two cycles later `done=1`, `pass=1`, `cmp_count=3`, `err_count=0`.
- Mismatch: expected 0xA5, actual 0x5A.
  - The cycle after the handshake, `mismatch=1` for one cycle and `err_count=1`.
  - `first_err_exp=0xA5`, `first_err_act=0x5A`.
  - A second mismatch (0x01 vs 0x02) leaves `first_err_*` unchanged.
- Full: push 8 entries with no actuals. `exp_ready=0` after the 8th push and the 9th is held. One act handshake re-raises `exp_ready` the next cycle, and the held 9th push is then accepted.
- Leftover at finish: push 4, match 1, then `finish` with a handshake in the same cycle. After FLUSH, `err_count=2`, `cmp_count=2`, `pass=0`.
- Start/finish collision: assert both in RUN with `err_count=3`. The block stays in RUN with counters cleared and `done=0`.
